// File: rtl/bl_transpose_pkg.sv
// Shared types and constants for the 8x8 row-to-column transpose buffer.
package bl_transpose_pkg;

  localparam int W     = 9;
  localparam int LANES = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    EOS_OUT = 2'd2
  } state_t;

  typedef logic [LANES-1:0][W-1:0] lane_vec_t;

  function automatic logic all_lanes(input logic [LANES-1:0] v);
    return &v;
  endfunction

endpackage

// File: rtl/bl_transpose_ctl.sv
// Sequencing for the transpose buffer: fill/drain FSM, row and column
// counters, pending end-of-stream flag and the handshake decode.
module bl_transpose_ctl
  import bl_transpose_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [LANES-1:0] in_vld,
  input  logic             in_eos,
  input  logic [LANES-1:0] out_bp,
  output logic [LANES-1:0] in_bp,
  output logic             wr_row,
  output logic             zero_tail,
  output logic [2:0]       row,
  output logic [2:0]       col,
  output state_t           state
);

  logic fill_ok;
  logic in_fire;
  logic out_fire;
  logic pend_eos;

  // fill_ok ignores reset so reset never reaches a data flop; only the
  // back-pressure output is gated by it.
  assign fill_ok   = (state == FILL) && all_lanes(in_vld);
  assign in_fire   = fill_ok && reset;
  assign in_bp     = {LANES{~in_fire}};
  assign out_fire  = (state != FILL) && (out_bp == '0);
  assign wr_row    = fill_ok && !in_eos;
  assign zero_tail = fill_ok && in_eos && (row != 3'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= FILL;
      row      <= 3'd0;
      col      <= 3'd0;
      pend_eos <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            if (!in_eos) begin
              if (row == 3'd7) begin
                state <= DRAIN;
                row   <= 3'd0;
                col   <= 3'd0;
              end else begin
                row <= row + 3'd1;
              end
            end else if (row == 3'd0) begin
              state <= EOS_OUT;
            end else begin
              // Short block: tail rows are cleared by the buffer this cycle.
              pend_eos <= 1'b1;
              state    <= DRAIN;
              col      <= 3'd0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (col == 3'd7) begin
              col <= 3'd0;
              row <= 3'd0;
              state <= pend_eos ? EOS_OUT : FILL;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        EOS_OUT: begin
          if (out_fire) begin
            pend_eos <= 1'b0;
            row      <= 3'd0;
            state    <= FILL;
          end
        end
        default: begin
          state <= FILL;
          row   <= 3'd0;
          col   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bl_transpose8x8.sv
// Single-bank 8x8 transpose: eight row vectors in, eight column vectors out,
// with fill and drain phases alternating.
module bl_transpose8x8
  import bl_transpose_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a_d,
  input  logic [W-1:0] b_d,
  input  logic [W-1:0] c_d,
  input  logic [W-1:0] d_d,
  input  logic [W-1:0] e_d,
  input  logic [W-1:0] f_d,
  input  logic [W-1:0] g_d,
  input  logic [W-1:0] h_d,
  input  logic         a_e,
  input  logic         b_e,
  input  logic         c_e,
  input  logic         d_e,
  input  logic         e_e,
  input  logic         f_e,
  input  logic         g_e,
  input  logic         h_e,
  input  logic         a_v,
  input  logic         b_v,
  input  logic         c_v,
  input  logic         d_v,
  input  logic         e_v,
  input  logic         f_v,
  input  logic         g_v,
  input  logic         h_v,
  output logic         a_b,
  output logic         b_b,
  output logic         c_b,
  output logic         d_b,
  output logic         e_b,
  output logic         f_b,
  output logic         g_b,
  output logic         h_b,
  output logic [W-1:0] s_d,
  output logic [W-1:0] t_d,
  output logic [W-1:0] u_d,
  output logic [W-1:0] v_d,
  output logic [W-1:0] w_d,
  output logic [W-1:0] x_d,
  output logic [W-1:0] y_d,
  output logic [W-1:0] z_d,
  output logic         s_e,
  output logic         t_e,
  output logic         u_e,
  output logic         v_e,
  output logic         w_e,
  output logic         x_e,
  output logic         y_e,
  output logic         z_e,
  output logic         s_v,
  output logic         t_v,
  output logic         u_v,
  output logic         v_v,
  output logic         w_v,
  output logic         x_v,
  output logic         y_v,
  output logic         z_v,
  input  logic         s_b,
  input  logic         t_b,
  input  logic         u_b,
  input  logic         v_b,
  input  logic         w_b,
  input  logic         x_b,
  input  logic         y_b,
  input  logic         z_b
);

  lane_vec_t        row_in;
  lane_vec_t        col_sel;
  lane_vec_t        dout;
  lane_vec_t        rows [LANES];
  logic [LANES-1:0] in_vld;
  logic [LANES-1:0] in_bp;
  logic [LANES-1:0] out_bp;
  logic             wr_row;
  logic             zero_tail;
  logic [2:0]       row;
  logic [2:0]       col;
  state_t           state;
  logic             out_vld;
  logic             out_eos;
  logic             unused_eos;

  assign row_in = {h_d, g_d, f_d, e_d, d_d, c_d, b_d, a_d};
  assign in_vld = {h_v, g_v, f_v, e_v, d_v, c_v, b_v, a_v};
  assign out_bp = {z_b, y_b, x_b, w_b, v_b, u_b, t_b, s_b};

  // Only lane a carries end-of-stream; the other lanes' flags are ignored.
  assign unused_eos = ^{b_e, c_e, d_e, e_e, f_e, g_e, h_e};

  bl_transpose_ctl u_ctl (
    .clock     (clock),
    .reset     (reset),
    .in_vld    (in_vld),
    .in_eos    (a_e),
    .out_bp    (out_bp),
    .in_bp     (in_bp),
    .wr_row    (wr_row),
    .zero_tail (zero_tail),
    .row       (row),
    .col       (col),
    .state     (state)
  );

  // Row write on accept; an early end-of-stream clears the unfilled rows.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_row && (row == 3'(i))) begin
        rows[i] <= row_in;
      end else if (zero_tail && (3'(i) >= row)) begin
        rows[i] <= '0;
      end
    end
  end

  always_comb begin
    col_sel = '0;
    for (int k = 0; k < LANES; k++) begin
      col_sel[k] = rows[k][col];
    end
  end

  assign dout    = (state == DRAIN) ? col_sel : '0;
  assign out_vld = (state != FILL);
  assign out_eos = (state == EOS_OUT);

  assign {h_b, g_b, f_b, e_b, d_b, c_b, b_b, a_b} = in_bp;
  assign {z_d, y_d, x_d, w_d, v_d, u_d, t_d, s_d} = dout;
  assign {z_e, y_e, x_e, w_e, v_e, u_e, t_e, s_e} = {LANES{out_eos}};
  assign {z_v, y_v, x_v, w_v, v_v, u_v, t_v, s_v} = {LANES{out_vld}};

endmodule

// File: tb/tb_bl_transpose8x8.sv
// Randomized bench for bl_transpose8x8 with a queue-based transpose model.
module tb_bl_transpose8x8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [71:0] in_dp = '0;
  logic [7:0]  in_e  = '0;
  logic [7:0]  in_v  = '0;
  logic [7:0]  out_b = '0;
  wire  [7:0]  a_b;
  wire  [71:0] out_dp;
  wire  [7:0]  out_e;
  wire  [7:0]  out_v;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          last_in_cyc = 0;
  logic        last_in_fire = 1'b0;
  logic        rand_bp = 1'b0;
  logic [79:0] exp_q [$];
  logic [79:0] out_q [$];
  logic [71:0] mrow_q [$];

  always #5 clock = ~clock;

  bl_transpose8x8 dut (
    .clock(clock), .reset(reset),
    .a_d(in_dp[8:0]),   .b_d(in_dp[17:9]),  .c_d(in_dp[26:18]), .d_d(in_dp[35:27]),
    .e_d(in_dp[44:36]), .f_d(in_dp[53:45]), .g_d(in_dp[62:54]), .h_d(in_dp[71:63]),
    .a_e(in_e[0]), .b_e(in_e[1]), .c_e(in_e[2]), .d_e(in_e[3]),
    .e_e(in_e[4]), .f_e(in_e[5]), .g_e(in_e[6]), .h_e(in_e[7]),
    .a_v(in_v[0]), .b_v(in_v[1]), .c_v(in_v[2]), .d_v(in_v[3]),
    .e_v(in_v[4]), .f_v(in_v[5]), .g_v(in_v[6]), .h_v(in_v[7]),
    .a_b(a_b[0]), .b_b(a_b[1]), .c_b(a_b[2]), .d_b(a_b[3]),
    .e_b(a_b[4]), .f_b(a_b[5]), .g_b(a_b[6]), .h_b(a_b[7]),
    .s_d(out_dp[8:0]),   .t_d(out_dp[17:9]),  .u_d(out_dp[26:18]), .v_d(out_dp[35:27]),
    .w_d(out_dp[44:36]), .x_d(out_dp[53:45]), .y_d(out_dp[62:54]), .z_d(out_dp[71:63]),
    .s_e(out_e[0]), .t_e(out_e[1]), .u_e(out_e[2]), .v_e(out_e[3]),
    .w_e(out_e[4]), .x_e(out_e[5]), .y_e(out_e[6]), .z_e(out_e[7]),
    .s_v(out_v[0]), .t_v(out_v[1]), .u_v(out_v[2]), .v_v(out_v[3]),
    .w_v(out_v[4]), .x_v(out_v[5]), .y_v(out_v[6]), .z_v(out_v[7]),
    .s_b(out_b[0]), .t_b(out_b[1]), .u_b(out_b[2]), .v_b(out_b[3]),
    .w_b(out_b[4]), .x_b(out_b[5]), .y_b(out_b[6]), .z_b(out_b[7])
  );

  // Reference: collect rows, emit the transposed block as column tokens.
  task automatic emit_block();
    logic [71:0] d;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) d[9*k +: 9] = mrow_q[k][9*c +: 9];
      exp_q.push_back({8'h00, d});
    end
    mrow_q.delete();
  endtask

  task automatic model_in(input logic [71:0] row, input logic eos);
    if (!eos) begin
      mrow_q.push_back(row);
      if (mrow_q.size() == 8) emit_block();
    end else begin
      if (mrow_q.size() != 0) begin
        while (mrow_q.size() < 8) mrow_q.push_back('0);
        emit_block();
      end
      exp_q.push_back({8'hFF, 72'd0});
    end
  endtask

  task automatic step();
    if (rand_bp) out_b = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
    @(negedge clock);
    last_in_fire = (&in_v) && (a_b == 8'h00);
    if (last_in_fire) begin
      model_in(in_dp, in_e[0]);
      last_in_cyc = cyc;
    end
    if ((&out_v) && (out_b == 8'h00)) out_q.push_back({out_e, out_dp});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send_row(input logic [71:0] row, input logic eos, input logic skew);
    in_dp = row;
    in_e = 8'($urandom);
    in_e[0] = eos;
    for (int n = 0; n < 200; n++) begin
      in_v = (skew && ($urandom_range(0, 3) == 0)) ? 8'($urandom) : 8'hFF;
      step();
      if (last_in_fire) break;
    end
    total_cnt++;
    if (!last_in_fire) $display("FAIL send_row_accept got none within 200 cycles required accept");
    else pass_cnt++;
    in_v = 8'h00;
  endtask

  task automatic drain();
    in_v = 8'h00;
    for (int n = 0; n < 300 && out_q.size() < exp_q.size(); n++) step();
    step();
    step();
  endtask

  task automatic test_reset();
    in_v = 8'hFF;
    #3;
    total_cnt++; if (out_v !== 8'h00) $display("FAIL reset_valid got %h required 00", out_v); else pass_cnt++;
    total_cnt++; if (out_e !== 8'h00) $display("FAIL reset_eos got %h required 00", out_e); else pass_cnt++;
    total_cnt++; if (out_dp !== 72'd0) $display("FAIL reset_data got %h required 0", out_dp); else pass_cnt++;
    total_cnt++; if (a_b !== 8'hFF) $display("FAIL reset_bp got %h required ff", a_b); else pass_cnt++;
    #9;
    reset = 1'b1;
    #1;
    total_cnt++; if (a_b !== 8'h00) $display("FAIL release_bp got %h required 00", a_b); else pass_cnt++;
    in_v = 8'h00;
    @(posedge clock);
    #1;
  endtask

  task automatic test_identity();
    logic [71:0] r;
    logic [71:0] col;
    int t0;
    out_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) r[9*k +: 9] = 9'(8*i + k);
      send_row(r, 1'b0, 1'b0);
      if (i == 0) t0 = last_in_cyc;
    end
    for (int k = 0; k < 8; k++) col[9*k +: 9] = 9'(8*k);
    total_cnt++;
    if (out_v !== 8'hFF || out_e !== 8'h00 || out_dp !== col)
      $display("FAIL identity_latency got v=%h d=%h required v=ff d=%h", out_v, out_dp, col);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
      if (i == 0) begin
        total_cnt++;
        if (last_in_cyc - t0 != 16) $display("FAIL identity_period got %0d required 16", last_in_cyc - t0);
        else pass_cnt++;
      end
    end
    drain();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) col[9*k +: 9] = 9'(8*k + c);
      total_cnt++;
      if (c >= out_q.size() || out_q[c] !== {8'h00, col})
        $display("FAIL identity_col%0d got %h required %h", c, (c < out_q.size()) ? out_q[c] : 80'd0, {8'h00, col});
      else pass_cnt++;
    end
    total_cnt++;
    if (out_q.size() != exp_q.size()) $display("FAIL identity_count got %0d required %0d", out_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL identity_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_output_stall();
    logic [71:0] m [8];
    logic [71:0] col2;
    for (int i = 0; i < 8; i++) begin
      m[i] = {$urandom, $urandom, $urandom};
      send_row(m[i], 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) col2[9*k +: 9] = m[k][18 +: 9];
    step();
    step();
    out_b = 8'h01;
    in_v = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      step();
      total_cnt++;
      if (out_v !== 8'hFF || out_dp !== col2) $display("FAIL stall_hold%0d got v=%h d=%h required v=ff d=%h", n, out_v, out_dp, col2);
      else pass_cnt++;
      total_cnt++;
      if (a_b !== 8'hFF) $display("FAIL stall_bp%0d got %h required ff", n, a_b);
      else pass_cnt++;
    end
    out_b = 8'h00;
    drain();
    total_cnt++;
    if (out_q.size() != exp_q.size()) $display("FAIL stall_count got %0d required %0d", out_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL stall_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_skewed_inputs();
    in_dp = {$urandom, $urandom, $urandom};
    in_e = 8'h00;
    in_v = 8'h7F;
    for (int n = 0; n < 4; n++) begin
      #1;
      total_cnt++;
      if (a_b !== 8'hFF) $display("FAIL skew_bp%0d got %h required ff", n, a_b);
      else pass_cnt++;
      step();
    end
    in_v = 8'hFF;
    #1;
    total_cnt++;
    if (a_b !== 8'h00) $display("FAIL skew_accept got %h required 00", a_b);
    else pass_cnt++;
    step();
    in_v = 8'h00;
    for (int i = 1; i < 8; i++) send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    drain();
    total_cnt++;
    if (out_q.size() != exp_q.size()) $display("FAIL skew_count got %0d required %0d", out_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL skew_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_eos_boundary();
    for (int i = 0; i < 16; i++) send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    send_row({$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    drain();
    total_cnt++;
    if (out_q.size() != 17 || exp_q.size() != 17) $display("FAIL eos_count got %0d required 17", out_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL eos_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    in_v = 8'hFF;
    #1;
    total_cnt++;
    if (out_v !== 8'h00 || a_b !== 8'h00) $display("FAIL eos_back_to_fill got v=%h b=%h required v=00 b=00", out_v, a_b);
    else pass_cnt++;
    in_v = 8'h00;
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial_eos();
    for (int i = 0; i < 3; i++) send_row({8{9'h1FF}}, 1'b0, 1'b0);
    send_row({$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    drain();
    total_cnt++;
    if (out_q.size() == 0 || out_q[0] !== {8'h00, 45'd0, {3{9'h1FF}}})
      $display("FAIL partial_col0 got %h required %h", (out_q.size() > 0) ? out_q[0] : 80'd0, {8'h00, 45'd0, {3{9'h1FF}}});
    else pass_cnt++;
    total_cnt++;
    if (out_q.size() != 9 || exp_q.size() != 9) $display("FAIL partial_count got %0d required 9", out_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL partial_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 8; i++) send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) step();
    in_v = 8'hFF;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (out_v !== 8'h00 || out_e !== 8'h00 || out_dp !== 72'd0)
      $display("FAIL midreset_out got v=%h e=%h d=%h required all zero", out_v, out_e, out_dp);
    else pass_cnt++;
    total_cnt++;
    if (a_b !== 8'hFF) $display("FAIL midreset_bp got %h required ff", a_b);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_b !== 8'hFF || out_v !== 8'h00) $display("FAIL midreset_hold got b=%h v=%h required b=ff v=00", a_b, out_v);
    else pass_cnt++;
    mrow_q.delete(); exp_q.delete(); out_q.delete();
    in_v = 8'h00;
    #3;
    reset = 1'b1;
    step();
    total_cnt++;
    if (out_v !== 8'h00) $display("FAIL midreset_stale got v=%h required 00", out_v);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    drain();
    total_cnt++;
    if (out_q.size() != 8) $display("FAIL midreset_count got %0d required 8", out_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL midreset_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    out_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_traffic();
    int n;
    rand_bp = 1'b1;
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(0, 10);
      if (n >= 8) begin
        for (int i = 0; i < 8; i++) send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b1);
      end else begin
        for (int i = 0; i < n; i++) send_row({$urandom, $urandom, $urandom}, 1'b0, 1'b1);
        send_row({$urandom, $urandom, $urandom}, 1'b1, 1'b1);
      end
    end
    drain();
    rand_bp = 1'b0;
    out_b = 8'h00;
    total_cnt++;
    if (out_q.size() != exp_q.size()) $display("FAIL random_count got %0d required %0d", out_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) if (i < out_q.size()) begin
      total_cnt++;
      if (out_q[i] !== exp_q[i]) $display("FAIL random_tok%0d got %h required %h", i, out_q[i], exp_q[i]);
      else pass_cnt++;
    end
    out_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_output_stall();
    test_skewed_inputs();
    test_eos_boundary();
    test_partial_eos();
    test_reset_mid_drain();
    test_random_traffic();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bl_transpose8x8.md
# bl_transpose8x8

Row-to-column transpose buffer for the JPEG IDCT datapath. It sits directly downstream of the first-dimension butterfly page (bl_d1), whose eight 9-bit output streams each carry one coefficient lane of a row. The block collects eight such rows into an 8x8 buffer, then emits the block column by column on eight output streams, so the second-dimension pass gets column vectors. Single-bank design: fill and drain alternate, which gives 16 cycles per block when nothing stalls.

## Interface
- W, 9, data width of every lane. Lane count is fixed at 8.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_d..h_d  in  W  row lanes 0..7 from bl_d1.
- a_e..h_e  in  1  end-of-stream flag per lane.
- a_v..h_v  in  1  valid per lane.
- a_b..h_b  out  1  back-pressure per lane. 1 means the block will not accept.
- s_d..z_d  out  W  column lanes. s is row 0 of the column and z is row 7.
- s_e..z_e  out  1  end-of-stream flag per lane.
- s_v..z_v  out  1  valid per lane.
- s_b..z_b  in  1  back-pressure from the consumer per lane.

## Operation
- A token moves on a lane when that lane has _v=1 and _b=0.
- Input fire: state FILL, all eight a_v..h_v = 1, and reset deasserted.
  - Every a_b..h_b equals ~fire, so all eight lanes are consumed atomically.
  - _e is taken from a_e only; b_e..h_e are ignored.
- Output fire: outputs valid and all eight s_b..z_b = 0.
- States:
  - FILL, row counter r = 0..7. On fire with a_e=0, write buf[r][k] = lane k and increment r. When r=7 fires, go to DRAIN with c=0.
  - FILL with a_e=1 and r=0: consume the token and go to EOS_OUT.
  - FILL with a_e=1 and r>0: consume the token, zero rows r..7, set the pending-EOS flag, and go to DRAIN.
  - DRAIN, column counter c = 0..7. All _v = 1, _e = 0, lane k _d = buf[k][c]. On output fire, increment c. At c=7, go to EOS_OUT if pending-EOS is set, otherwise go to FILL with r=0.
  - EOS_OUT. All _v = 1, all _e = 1, all _d = 0. On output fire, clear pending-EOS and go to FILL with r=0.
- Counters are 3-bit and wrap only through the transitions above.
- Data passes through with no arithmetic; all W bits are preserved.
- Outputs depend only on registered state. There is no combinational path from any input to s..z.
- The only combinational input-to-output path is a_v..h_v to a_b..h_b.
- Reset (asynchronous, mid-operation included):
  - state = FILL, r = 0, c = 0, pending-EOS = 0.
  - All s..z _v, _e and _d = 0.
  - All a_b..h_b = 1 while reset = 0.
  - Buffer contents are don't-care, and any partial block is discarded.

## Timing
- Input fire at edge N for row 7: s..z _v = 1 with column 0 from cycle N+1.
- No stalls: 8 fill cycles plus 8 drain cycles per block.
- Output stall (any s_b..z_b = 1): data and valid hold stable until output fire.
- Input lanes valid on different cycles: no lane is consumed until all eight are valid.
- During DRAIN and EOS_OUT, a_b..h_b = 1 regardless of a_v..h_v.
- Reset deasserting between edges: the first fire is possible at the first edge with reset = 1.

## Structure
- Package bl_transpose_pkg:
  - Constants: W=9, LANES=8.
  - State enum: FILL, DRAIN, EOS_OUT.
  - Lane-vector typedef: logic [LANES-1:0][W-1:0].
- Buffer: 64xW flop array inside the top module, written a row at a time and read a column at a time through a 3-bit column mux.
- One sub-module is natural: bl_transpose_ctl, holding the FSM, r, c, pending-EOS, and the fire/back-pressure logic.

## Test plan
- Identity block: row i lane k = 8i+k (0..63), no stalls.
  - Column c emits s..z = c, 8+c, ..., 56+c.
  - First output valid one cycle after row 7 is accepted; 16 cycles per block.
- Output stall: hold s_b=1 for 3 cycles during column 2.
  - Outputs stay at column 2 values until released.
  - c does not advance, and a_b..h_b stay 1.
- Skewed inputs: a_v..g_v=1 with h_v=0 for 4 cycles.
  - No write; all a_b..h_b=1.
  - Accepted on the first cycle h_v=1.
- EOS at block boundary: 2 full blocks, then a_e=1 with r=0.
  - 16 column tokens, then one token with all _e=1 and _d=0, then state FILL.
- Partial EOS: 3 rows of value 0x1FF, then a_e=1.
  - Columns show s..u = 0x1FF and v..z = 0.
  - Then the EOS token.
- Reset mid-DRAIN at c=4:
  - All _v=0 and a_b..h_b=1 during reset.
  - After release, a fresh block starts at row 0 and no stale columns are emitted.
